// File: rtl/point_entry_pkg.sv
// -----------------------------------------------------------------------------
// point_entry_pkg
// Shared definitions for the point-entry block: default timing constants and
// the controller state encoding.
// -----------------------------------------------------------------------------
package point_entry_pkg;

    // 10 ms of stable level at 100 MHz before a button change is accepted.
    localparam int unsigned DEB_CYCLES_DEFAULT     = 32'd1000000;
    // 0.5 s at 100 MHz during which presses are ignored after a point.
    localparam int unsigned LOCKOUT_CYCLES_DEFAULT = 32'd50000000;

    // Controller states.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE         = 2'd0;
    localparam state_t ST_ISSUE        = 2'd1;
    localparam state_t ST_LOCKOUT      = 2'd2;
    localparam state_t ST_WAIT_RELEASE = 2'd3;

endpackage

// File: rtl/button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
// Synchronizes one raw bouncy button, debounces it and produces a single-cycle
// registered pulse on each accepted 0->1 change of the debounced level.
//   clk    : system clock
//   reset  : synchronous, active-low
//   btn    : raw asynchronous button, active-high
//   level  : debounced level (resets to 1 so a held button is not a press)
//   press  : one-cycle pulse after the debounced level rises
// -----------------------------------------------------------------------------
module button_debounce
    import point_entry_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int W = $clog2(DEB_CYCLES + 1);
    localparam logic [W-1:0] DEB_LAST = W'(DEB_CYCLES - 1);
    localparam logic [W-1:0] CNT_ONE  = W'(1);

    logic         sync1_r;
    logic         sync2_r;
    logic         deb_r;
    logic         deb_prev_r;
    logic         press_r;
    logic [W-1:0] cnt_r;

    // Synchronizer, debounce counter and rising-edge pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_r    <= 1'b0;
            sync2_r    <= 1'b0;
            deb_r      <= 1'b1;
            deb_prev_r <= 1'b1;
            press_r    <= 1'b0;
            cnt_r      <= '0;
        end else begin
            sync1_r    <= btn;
            sync2_r    <= sync1_r;
            deb_prev_r <= deb_r;
            press_r    <= deb_r & ~deb_prev_r;
            // Count consecutive cycles of disagreement; any agreement restarts.
            if (sync2_r != deb_r) begin
                if (cnt_r == DEB_LAST) begin
                    deb_r <= sync2_r;
                    cnt_r <= '0;
                end else begin
                    cnt_r <= cnt_r + CNT_ONE;
                end
            end else begin
                cnt_r <= '0;
            end
        end
    end

    assign level = deb_r;
    assign press = press_r;

endmodule

// File: rtl/point_entry.sv
// -----------------------------------------------------------------------------
// point_entry
// Turns two bouncy team buttons into single-cycle point strobes, with a
// lockout after every point and a conflict pulse on simultaneous presses.
//   clk       : system clock
//   reset     : synchronous, active-low
//   btn1/btn2 : raw team buttons, active-high
//   enable    : 1 allows new points to be entered
//   one_point : one-cycle point strobe
//   team      : 1 = team 1, 0 = team 2; held until the next point
//   busy      : 1 while in lockout or waiting for both buttons released
//   conflict  : one-cycle pulse when both buttons press together
// -----------------------------------------------------------------------------
module point_entry
    import point_entry_pkg::*;
#(
    parameter int unsigned DEB_CYCLES     = DEB_CYCLES_DEFAULT,
    parameter int unsigned LOCKOUT_CYCLES = LOCKOUT_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic btn1,
    input  logic btn2,
    input  logic enable,
    output logic one_point,
    output logic team,
    output logic busy,
    output logic conflict
);

    localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCKOUT_CYCLES - 1);
    localparam logic [LW-1:0] LOCK_ONE  = LW'(1);

    logic          level1_s;
    logic          level2_s;
    logic          press1_s;
    logic          press2_s;
    state_t        state_r;
    state_t        state_next_s;
    logic [LW-1:0] lock_cnt_r;
    logic          one_point_r;
    logic          team_r;
    logic          busy_r;
    logic          conflict_r;

    button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb1 (
        .clk   (clk),
        .reset (reset),
        .btn   (btn1),
        .level (level1_s),
        .press (press1_s)
    );

    button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb2 (
        .clk   (clk),
        .reset (reset),
        .btn   (btn2),
        .level (level2_s),
        .press (press2_s)
    );

    // Next-state decode; presses outside IDLE are simply not looked at.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (enable && press1_s && press2_s) begin
                    state_next_s = ST_WAIT_RELEASE;
                end else if (enable && (press1_s || press2_s)) begin
                    state_next_s = ST_ISSUE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_next_s = ST_LOCKOUT;
            end
            ST_LOCKOUT: begin
                if (lock_cnt_r == LOCK_LAST) begin
                    state_next_s = ST_WAIT_RELEASE;
                end else begin
                    state_next_s = ST_LOCKOUT;
                end
            end
            ST_WAIT_RELEASE: begin
                if (!level1_s && !level2_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_WAIT_RELEASE;
                end
            end
            default: begin
                state_next_s = ST_WAIT_RELEASE;
            end
        endcase
    end

    // State, lockout counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= ST_WAIT_RELEASE;
            lock_cnt_r  <= '0;
            one_point_r <= 1'b0;
            team_r      <= 1'b0;
            busy_r      <= 1'b1;
            conflict_r  <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            one_point_r <= (state_r == ST_ISSUE);
            conflict_r  <= (state_r == ST_IDLE) && enable && press1_s && press2_s;
            busy_r      <= (state_next_s == ST_LOCKOUT) || (state_next_s == ST_WAIT_RELEASE);
            // The counter only runs while staying in LOCKOUT, so each lockout starts at 0.
            if ((state_r == ST_LOCKOUT) && (state_next_s == ST_LOCKOUT)) begin
                lock_cnt_r <= lock_cnt_r + LOCK_ONE;
            end else begin
                lock_cnt_r <= '0;
            end
            // Exactly one press is present on this transition; btn1 means team 1.
            if ((state_r == ST_IDLE) && (state_next_s == ST_ISSUE)) begin
                team_r <= press1_s;
            end else begin
                team_r <= team_r;
            end
        end
    end

    assign one_point = one_point_r;
    assign team      = team_r;
    assign busy      = busy_r;
    assign conflict  = conflict_r;

endmodule

// File: tb/tb_point_entry.sv
// -----------------------------------------------------------------------------
// tb_point_entry
// Directed and random stimulus against a behavioural model of the point-entry
// rules; expected points/conflicts are queued with the cycle they must appear
// in and a separate monitor pops and compares them.
// -----------------------------------------------------------------------------
module tb_point_entry;

    localparam int DEB  = 4;
    localparam int LOCK = 8;

    localparam int M_IDLE = 0, M_ISSUE = 1, M_LOCK = 2, M_WAIT = 3;

    typedef struct {
        int stamp;
        bit team;
    } point_exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic btn1 = 1'b0;
    logic btn2 = 1'b0;
    logic enable = 1'b0;
    logic one_point, team, busy, conflict;

    int errors = 0;
    int checks = 0;
    int edge_cnt = 0;

    point_exp_t point_q[$];
    int         conf_q[$];
    bit         exp_busy = 1'b1;

    // Model state (spec-level view of each button and of the controller).
    bit m_s1[2], m_s2[2], m_deb[2];
    int m_run[2];
    bit m_pq[2][2];
    int m_mode = M_WAIT;
    int m_lock_end = 0;
    bit m_team = 1'b0;

    point_entry #(.DEB_CYCLES(DEB), .LOCKOUT_CYCLES(LOCK)) dut (
        .clk       (clk),
        .reset     (reset),
        .btn1      (btn1),
        .btn2      (btn2),
        .enable    (enable),
        .one_point (one_point),
        .team      (team),
        .busy      (busy),
        .conflict  (conflict)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Predict the DUT's outputs after posedge number n from the current inputs.
    task automatic model_step(input int n);
        bit raw[2];
        bit lv[2];
        bit pe[2];
        bit rise;
        raw[0] = btn1;
        raw[1] = btn2;
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                m_s1[i] = 1'b0; m_s2[i] = 1'b0; m_deb[i] = 1'b1; m_run[i] = 0;
                m_pq[i][0] = 1'b0; m_pq[i][1] = 1'b0;
            end
            m_mode   = M_WAIT;
            exp_busy = 1'b1;
            return;
        end
        for (int i = 0; i < 2; i++) begin
            lv[i] = m_deb[i];
            // A rise of the debounced level reaches the controller two cycles later.
            pe[i] = m_pq[i][0];
            m_pq[i][0] = m_pq[i][1];
            rise = 1'b0;
            if (m_s2[i] != m_deb[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB) begin
                    m_deb[i] = m_s2[i];
                    m_run[i] = 0;
                    rise = m_deb[i];
                end
            end else begin
                m_run[i] = 0;
            end
            m_pq[i][1] = rise;
            m_s2[i] = m_s1[i];
            m_s1[i] = raw[i];
        end
        if (m_mode == M_IDLE && enable && pe[0] && pe[1]) conf_q.push_back(n);
        case (m_mode)
            M_IDLE: begin
                if (enable && pe[0] && pe[1]) m_mode = M_WAIT;
                else if (enable && (pe[0] || pe[1])) begin
                    m_mode = M_ISSUE;
                    m_team = pe[0];
                end
            end
            M_ISSUE: begin
                point_q.push_back('{stamp: n, team: m_team});
                m_mode = M_LOCK;
                m_lock_end = n + LOCK;
            end
            M_LOCK: if (n == m_lock_end) m_mode = M_WAIT;
            default: if (!lv[0] && !lv[1]) m_mode = M_IDLE;
        endcase
        exp_busy = (m_mode == M_LOCK) || (m_mode == M_WAIT);
    endtask

    // Apply inputs for one cycle and advance the model to match.
    task automatic drive(input bit b1, input bit b2, input bit en, input bit rst_n);
        btn1 = b1; btn2 = b2; enable = en; reset = rst_n;
        model_step(edge_cnt);
        @(negedge clk);
        #1;
    endtask

    task automatic hold(input bit b1, input bit b2, input bit en, input bit rst_n, input int n);
        for (int k = 0; k < n; k++) drive(b1, b2, en, rst_n);
    endtask

    // Monitor: compare every cycle's outputs against queued expectations.
    initial begin
        forever begin
            @(negedge clk);
            checks++;
            if (busy !== exp_busy) begin
                errors++;
                $display("FAIL busy edge=%0d got=%b want=%b", edge_cnt - 1, busy, exp_busy);
            end
            while (point_q.size() > 0 && point_q[0].stamp < edge_cnt - 1) begin
                errors++; checks++;
                $display("FAIL point_missing edge=%0d got=0 want=1", point_q[0].stamp);
                void'(point_q.pop_front());
            end
            while (conf_q.size() > 0 && conf_q[0] < edge_cnt - 1) begin
                errors++; checks++;
                $display("FAIL conflict_missing edge=%0d got=0 want=1", conf_q[0]);
                void'(conf_q.pop_front());
            end
            if (one_point === 1'b1) begin
                checks++;
                if (point_q.size() == 0 || point_q[0].stamp != edge_cnt - 1) begin
                    errors++;
                    $display("FAIL point_unexpected edge=%0d got=1 want=0", edge_cnt - 1);
                end else begin
                    if (team !== point_q[0].team) begin
                        errors++;
                        $display("FAIL team edge=%0d got=%b want=%b", edge_cnt - 1, team, point_q[0].team);
                    end
                    void'(point_q.pop_front());
                end
            end else if (one_point !== 1'b0) begin
                errors++; checks++;
                $display("FAIL one_point_x edge=%0d got=%b want=0/1", edge_cnt - 1, one_point);
            end
            if (conflict === 1'b1) begin
                checks++;
                if (conf_q.size() == 0 || conf_q[0] != edge_cnt - 1) begin
                    errors++;
                    $display("FAIL conflict_unexpected edge=%0d got=1 want=0", edge_cnt - 1);
                end else begin
                    void'(conf_q.pop_front());
                end
            end
        end
    end

    // Stimulus: directed scenarios, then random button activity.
    initial begin
        bit b1, b2, en;
        int npoints;
        hold(0, 0, 1, 0, 3);
        hold(0, 0, 1, 1, 12);
        // Clean btn1 press.
        hold(1, 0, 1, 1, 20);
        hold(0, 0, 1, 1, 20);
        // Bouncing btn2 then stable.
        for (int k = 0; k < 10; k++) drive(0, ((k / 2) % 2) == 0, 1, 1);
        hold(0, 1, 1, 1, 20);
        hold(0, 0, 1, 1, 20);
        // Simultaneous presses.
        hold(1, 1, 1, 1, 20);
        hold(0, 0, 1, 1, 20);
        // btn2 arriving during the lockout after a btn1 point.
        hold(1, 0, 1, 1, 11);
        hold(1, 1, 1, 1, 10);
        hold(0, 0, 1, 1, 20);
        // btn1 held through reset, then released and pressed again.
        hold(1, 0, 1, 1, 5);
        hold(1, 0, 1, 0, 3);
        hold(1, 0, 1, 1, 20);
        hold(0, 0, 1, 1, 20);
        hold(1, 0, 1, 1, 20);
        hold(0, 0, 1, 1, 20);
        // Press while disabled, enable while still held, then re-press.
        hold(1, 0, 0, 1, 15);
        hold(1, 0, 1, 1, 15);
        hold(0, 0, 1, 1, 20);
        hold(1, 0, 1, 1, 20);
        hold(0, 0, 1, 1, 20);
        // Reset in the middle of a debounce and in the middle of a lockout.
        hold(0, 1, 1, 1, 4);
        hold(0, 1, 1, 0, 2);
        hold(0, 0, 1, 1, 15);
        hold(0, 1, 1, 1, 11);
        hold(0, 1, 1, 0, 2);
        hold(0, 0, 1, 1, 15);
        // Random activity.
        b1 = 0; b2 = 0; en = 1;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 11) == 0) b1 = ~b1;
            if ($urandom_range(0, 11) == 0) b2 = ~b2;
            if ($urandom_range(0, 39) == 0) en = ~en;
            if ($urandom_range(0, 299) == 0) hold(b1, b2, en, 0, 2);
            else drive(b1, b2, en, 1);
        end
        hold(0, 0, 1, 1, 30);
        npoints = point_q.size() + conf_q.size();
        checks++;
        if (npoints != 0) begin
            errors++;
            $display("FAIL pending_expectations got=%0d want=0", npoints);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
